sram_rw_ctrl: RTL



---
 rtl/sram_rw_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sram_rw_ctrl.sv
// sram_rw_ctrl: valid/ready requester front end for a single-port masked-write SRAM with a 2-entry read response FIFO.
// Define SRAM_CTRL_INIT_EN to zero-fill the whole array after every reset release before accepting requests.
module sram_rw_ctrl #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 786,
  parameter int MASK_W = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              init_done
);

  logic              run_s;
  logic              init_wr_s;
  logic [ADDR_W-1:0] init_addr_s;

`ifdef SRAM_CTRL_INIT_EN
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e            state_r;
  state_e            state_next_s;
  logic [ADDR_W-1:0] init_cnt_r;

  // State register and zero-fill address walker
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_INIT;
      init_cnt_r <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_INIT) begin
        init_cnt_r <= init_cnt_r + ADDR_W'(1'b1);
      end else begin
        init_cnt_r <= init_cnt_r;
      end
    end
  end

  // Next state: leave INIT once the last address has been written
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_cnt_r == {ADDR_W{1'b1}}) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = ST_INIT;
    endcase
  end

  // State decode; init writes are held off while reset is asserted
  always_comb begin
    run_s     = 1'b0;
    init_wr_s = 1'b0;
    case (state_r)
      ST_INIT: begin
        run_s     = 1'b0;
        init_wr_s = reset_n;
      end
      ST_RUN: begin
        run_s     = 1'b1;
        init_wr_s = 1'b0;
      end
      default: begin
        run_s     = 1'b0;
        init_wr_s = 1'b0;
      end
    endcase
  end

  assign init_addr_s = init_cnt_r;
  assign init_done   = (state_r == ST_RUN);
`else
  assign run_s       = reset_n;
  assign init_wr_s   = 1'b0;
  assign init_addr_s = {ADDR_W{1'b0}};
  assign init_done   = 1'b1;
`endif

  logic [DATA_W-1:0] buf_mem_r [2];
  logic              buf_wr_ptr_r;
  logic              buf_rd_ptr_r;
  logic [1:0]        buf_count_r;
  logic              inflight_r;
  logic [1:0]        occ_s;
  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic              rd_room_s;

  // A read is admitted only if its data will have a free slot, counting a pop happening now
  assign pop_s      = resp_valid & resp_ready;
  assign push_s     = inflight_r;
  assign occ_s      = buf_count_r + {1'b0, inflight_r};
  assign rd_room_s  = (occ_s - {1'b0, pop_s}) < 2'd2;
  assign req_ready  = run_s & (req_write | rd_room_s);
  assign issue_s    = req_valid & req_ready;
  assign resp_valid = (buf_count_r != 2'd0);
  assign resp_rdata = buf_mem_r[buf_rd_ptr_r];

  // SRAM port mux: init walker owns the macro during INIT, otherwise requests pass straight through
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = {ADDR_W{1'b0}};
    sram_wmask = {MASK_W{1'b0}};
    sram_wdata = {DATA_W{1'b0}};
    if (init_wr_s) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_addr_s;
      sram_wmask = {MASK_W{1'b1}};
      sram_wdata = {DATA_W{1'b0}};
    end else begin
      sram_en    = issue_s;
      sram_wmode = req_write;
      sram_addr  = req_addr;
      sram_wmask = req_wmask;
      sram_wdata = req_wdata;
    end
  end

  // Response FIFO bookkeeping and read-in-flight flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_r   <= 1'b0;
      buf_wr_ptr_r <= 1'b0;
      buf_rd_ptr_r <= 1'b0;
      buf_count_r  <= 2'd0;
    end else begin
      inflight_r <= issue_s & ~req_write;
      if (push_s) begin
        buf_wr_ptr_r <= ~buf_wr_ptr_r;
      end else begin
        buf_wr_ptr_r <= buf_wr_ptr_r;
      end
      if (pop_s) begin
        buf_rd_ptr_r <= ~buf_rd_ptr_r;
      end else begin
        buf_rd_ptr_r <= buf_rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   buf_count_r <= buf_count_r + 2'd1;
        2'b01:   buf_count_r <= buf_count_r - 2'd1;
        default: buf_count_r <= buf_count_r;
      endcase
    end
  end

  // Data storage needs no reset: the count alone decides which entries are valid
  always_ff @(posedge clock) begin
    if (push_s) begin
      buf_mem_r[buf_wr_ptr_r] <= sram_rdata;
    end else begin
      buf_mem_r[buf_wr_ptr_r] <= buf_mem_r[buf_wr_ptr_r];
    end
  end

endmodule
